// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared widths, op codes and state encoding for data_mem_xfer
package mem_xfer_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LEN_W  = 9;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_CP_RD = 3'd3,
        ST_CP_WR = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/data_mem_xfer_if.sv
// rtl/data_mem_xfer_if.sv - command, stream, memory and status signals of data_mem_xfer
interface data_mem_xfer_if #(
    parameter int DATA_W = mem_xfer_pkg::DEF_DATA_W,
    parameter int ADDR_W = mem_xfer_pkg::DEF_ADDR_W,
    parameter int LEN_W  = mem_xfer_pkg::DEF_LEN_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;
    logic              done;
    logic              err;

    // Host/memory side: issues commands, sources and sinks streams, returns read data
    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len,
        output in_data, in_valid, out_ready, mem_dout,
        input  cmd_ready, in_ready, out_data, out_valid,
        input  mem_addr, mem_din, mem_we, busy, done, err
    );

    // Transfer engine side
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len,
        input  in_data, in_valid, out_ready, mem_dout,
        output cmd_ready, in_ready, out_data, out_valid,
        output mem_addr, mem_din, mem_we, busy, done, err
    );

endinterface

// File: rtl/xfer_skid_fifo.sv
// rtl/xfer_skid_fifo.sv - 2-entry FIFO holding memory read data ahead of the out stream
module xfer_skid_fifo #(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] entry0_q;
    logic [DATA_W-1:0] entry1_q;
    logic [1:0]        count_q;

    // entry0 is always the head; a pop shifts entry1 down behind it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0_q <= push_data_i;
                    end else begin
                        entry1_q <= push_data_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0_q <= push_data_i;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = entry0_q;

endmodule

// File: rtl/data_mem_xfer.sv
// rtl/data_mem_xfer.sv - block-transfer initiator (READ/WRITE/COPY) for the single-port data memory
module data_mem_xfer
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic           clka,
    input  logic           rst,
    data_mem_xfer_if.slave bus
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_RD    = ST_RD;
    localparam logic [2:0] S_WR    = ST_WR;
    localparam logic [2:0] S_CP_RD = ST_CP_RD;
    localparam logic [2:0] S_CP_WR = ST_CP_WR;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic              inflight_q, inflight_d;
    logic              err_q;

    logic              cmd_accept;
    logic              out_valid_c;
    logic              fifo_pop;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [2:0]        fifo_demand;
    logic              issue_rd;
    logic              last_word;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_din_c;
    logic              mem_we_c;

    assign cmd_accept  = bus.cmd_valid && (state_q == S_IDLE);
    assign out_valid_c = (fifo_count != 2'd0);
    assign fifo_pop    = out_valid_c && bus.out_ready;

    // Slots already claimed in the 2-entry FIFO after this cycle's pop; a new
    // read is only issued when its data is guaranteed a slot on arrival.
    assign fifo_demand = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    assign issue_rd    = (state_q == S_RD) && (cnt_q < len_q) && (fifo_demand < 3'd2);
    assign last_word   = (cnt_q == len_q - LEN_W'(1));

    xfer_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i       (clka),
        .rst_i       (rst),
        .push_i      (inflight_q),
        .push_data_i (bus.mem_dout),
        .pop_i       (fifo_pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    // State, counters, read-in-flight flag and command capture on accept
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            inflight_q <= inflight_d;
            if (cmd_accept) begin
                src_q <= bus.cmd_src;
                dst_q <= bus.cmd_dst;
                len_q <= bus.cmd_len;
                err_q <= (bus.cmd_op == OP_RSVD);
            end
        end
    end

    // Next-state decode and memory-port muxing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pop_cnt_d  = pop_cnt_q;
        inflight_d = issue_rd;
        mem_addr_c = '0;
        mem_din_c  = '0;
        mem_we_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                pop_cnt_d = '0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        case (bus.cmd_op)
                            OP_READ:  state_d = S_RD;
                            OP_WRITE: state_d = S_WR;
                            OP_COPY:  state_d = S_CP_RD;
                            OP_RSVD:  state_d = S_DONE;
                            default:  state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_RD: begin
                if (issue_rd) begin
                    mem_addr_c = src_q + cnt_q[ADDR_W-1:0];
                    cnt_d      = cnt_q + LEN_W'(1);
                end
                if (fifo_pop) begin
                    pop_cnt_d = pop_cnt_q + LEN_W'(1);
                    if (pop_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WR: begin
                if (bus.in_valid) begin
                    mem_addr_c = dst_q + cnt_q[ADDR_W-1:0];
                    mem_din_c  = bus.in_data;
                    mem_we_c   = 1'b1;
                    cnt_d      = cnt_q + LEN_W'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CP_RD: begin
                mem_addr_c = src_q + cnt_q[ADDR_W-1:0];
                state_d    = S_CP_WR;
            end
            S_CP_WR: begin
                mem_addr_c = dst_q + cnt_q[ADDR_W-1:0];
                mem_din_c  = bus.mem_dout;
                mem_we_c   = 1'b1;
                cnt_d      = cnt_q + LEN_W'(1);
                state_d    = last_word ? S_DONE : S_CP_RD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.in_ready  = (state_q == S_WR);
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = fifo_head;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_din   = mem_din_c;
    assign bus.mem_we    = mem_we_c && !rst;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_data_mem_xfer.sv
// tb/tb_data_mem_xfer.sv - directed self-checking bench for data_mem_xfer with a 256x64 memory model
module tb_data_mem_xfer;
    import mem_xfer_pkg::*;

    localparam logic [63:0] WA = 64'hAAAA_0000_1111_0001;
    localparam logic [63:0] WB = 64'hBBBB_2222_3333_0002;
    localparam logic [63:0] WC = 64'hCCCC_4444_5555_0003;

    logic clka = 1'b0;
    logic rst;
    always #5 clka = ~clka;

    data_mem_xfer_if bus ();

    data_mem_xfer dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    logic [63:0] mem [256];
    logic        do_preload;
    int          we_total = 0;
    int          errors = 0;
    int          checks = 0;
    int          occ_max = 0;
    logic [63:0] got [$];
    logic [63:0] exp_q [$];

    always @(posedge clka) begin
        if (do_preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_din;
        end
        bus.mem_dout <= mem[bus.mem_addr];
    end

    always @(posedge clka) begin
        if (bus.mem_we) we_total <= we_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] src,
                             input logic [7:0] dst, input logic [8:0] len);
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(negedge clka);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b11;
        bus.cmd_src   = 8'h5A;
        bus.cmd_dst   = 8'hA5;
        bus.cmd_len   = 9'd1;
    endtask

    // Cycle 1 is the first cycle after the accept cycle
    task automatic collect_read(input int budget, input bit rand_rdy, input int stop_after,
                                output int first_cyc, output int done_cyc, output int done_cnt);
        first_cyc = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        got.delete();
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
            if (int'(dut.u_fifo.count_o) > occ_max) occ_max = int'(dut.u_fifo.count_o);
            if (done_cyc >= 0 && cyc > done_cyc) break;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (stop_after != 0 && got.size() == stop_after) begin
                @(negedge clka);
                break;
            end
            @(negedge clka);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        foreach (exp_q[k]) begin
            chk($sformatf("%s_w%0d", tag, k),
                (k < got.size()) ? got[k] : 64'hDEAD_DEAD_DEAD_DEAD, exp_q[k]);
        end
    endtask

    initial begin
        int fc, dc, dn, we0;
        rst           = 1'b1;
        do_preload    = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_src   = 8'h00;
        bus.cmd_dst   = 8'h00;
        bus.cmd_len   = 9'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clka);

        // Reset state: only cmd_ready high
        chk("reset_flags", 64'({bus.cmd_ready, bus.busy, bus.done, bus.err,
                                bus.out_valid, bus.in_ready, bus.mem_we}), 64'b1000000);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'h0);
        chk("reset_out_data", bus.out_data, 64'h0);
        rst        = 1'b0;
        do_preload = 1'b0;
        @(negedge clka);

        // READ wrapping past the top of memory, out_ready held high
        we0 = we_total;
        issue_cmd(OP_READ, 8'hFE, 8'h00, 9'd4);
        collect_read(40, 1'b0, 0, fc, dc, dn);
        exp_q = '{64'hFE, 64'hFF, 64'h00, 64'h01};
        check_words("rd1");
        chk("rd1_first_valid_cyc", 64'(fc), 64'd3);
        chk("rd1_done_cyc", 64'(dc), 64'd7);
        chk("rd1_done_cnt", 64'(dn), 64'd1);
        chk("rd1_no_write", 64'(we_total - we0), 64'd0);
        chk("rd1_idle_after", 64'(bus.cmd_ready), 64'd1);

        // READ with random backpressure
        issue_cmd(OP_READ, 8'h10, 8'h00, 9'd8);
        collect_read(200, 1'b1, 0, fc, dc, dn);
        exp_q = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h17};
        check_words("rd2");
        chk("rd2_done_cnt", 64'(dn), 64'd1);
        chk("rd2_occ_le2", 64'(occ_max <= 2), 64'd1);

        // WRITE three words with a one-cycle in_valid gap
        we0 = we_total;
        issue_cmd(OP_WRITE, 8'h00, 8'h20, 9'd3);
        chk("wr_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = WA;
        @(negedge clka);
        bus.in_valid = 1'b0;
        bus.in_data  = 64'h0;
        @(negedge clka);
        chk("wr_stall_busy", 64'({bus.busy, bus.done}), 64'b10);
        bus.in_valid = 1'b1;
        bus.in_data  = WB;
        @(negedge clka);
        bus.in_data  = WC;
        @(negedge clka);
        bus.in_valid = 1'b0;
        chk("wr_done", 64'({bus.done, bus.err, bus.in_ready}), 64'b100);
        chk("wr_mem20", mem[8'h20], WA);
        chk("wr_mem21", mem[8'h21], WB);
        chk("wr_mem22", mem[8'h22], WC);
        chk("wr_mem23_untouched", mem[8'h23], 64'h23);
        chk("wr_mem1f_untouched", mem[8'h1F], 64'h1F);
        chk("wr_we_cycles", 64'(we_total - we0), 64'd3);
        @(negedge clka);

        // COPY with overlapping ranges, dst above src
        we0 = we_total;
        issue_cmd(OP_COPY, 8'h00, 8'h02, 9'd4);
        dc = -1;
        for (int cyc = 1; cyc <= 30 && dc < 0; cyc++) begin
            if (bus.done) dc = cyc;
            else @(negedge clka);
        end
        chk("cp_done_cyc", 64'(dc), 64'd9);
        chk("cp_mem2", mem[2], 64'h0);
        chk("cp_mem3", mem[3], 64'h1);
        chk("cp_mem4", mem[4], 64'h0);
        chk("cp_mem5", mem[5], 64'h1);
        chk("cp_mem6_untouched", mem[6], 64'h6);
        chk("cp_we_cycles", 64'(we_total - we0), 64'd4);
        @(negedge clka);

        // Zero length and reserved op complete immediately without memory writes
        we0 = we_total;
        issue_cmd(OP_WRITE, 8'h00, 8'h30, 9'd0);
        chk("len0_done", 64'({bus.done, bus.err, bus.cmd_ready, bus.in_ready}), 64'b1000);
        @(negedge clka);
        chk("len0_idle", 64'({bus.done, bus.cmd_ready}), 64'b01);
        issue_cmd(OP_RSVD, 8'h00, 8'h30, 9'd5);
        chk("rsvd_done_err", 64'({bus.done, bus.err, bus.busy}), 64'b111);
        @(negedge clka);
        chk("rsvd_idle", 64'({bus.done, bus.err, bus.cmd_ready}), 64'b001);
        chk("len0_rsvd_no_we", 64'(we_total - we0), 64'd0);
        chk("rsvd_mem30_untouched", mem[8'h30], 64'h30);

        // Reset mid-READ after five words, then a fresh READ of the written data
        issue_cmd(OP_READ, 8'h40, 8'h00, 9'd16);
        collect_read(60, 1'b0, 5, fc, dc, dn);
        chk("abort_words_before", 64'(got.size()), 64'd5);
        chk("abort_no_done_before", 64'(dn), 64'd0);
        rst = 1'b1;
        @(negedge clka);
        chk("abort_idle", 64'({bus.cmd_ready, bus.busy, bus.out_valid, bus.done}), 64'b1000);
        rst = 1'b0;
        @(negedge clka);
        chk("abort_no_done_after", 64'({bus.done, bus.out_valid}), 64'b00);
        issue_cmd(OP_READ, 8'h20, 8'h00, 9'd3);
        collect_read(40, 1'b0, 0, fc, dc, dn);
        exp_q = '{WA, WB, WC};
        check_words("rd3");
        chk("rd3_first_valid_cyc", 64'(fc), 64'd3);
        chk("rd3_done_cnt", 64'(dn), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
